dezigzag_rowbuffer64x8bit: RTL

//  Inverse-zigzag buffer for the JPEG decode path: accepts one 8x8 block of quantised

---
 rtl/dezigzag_rowbuffer64x8bit_pkg.sv | 34 +++
 rtl/dezigzag_rowbuffer64x8bit_zigzag_index_rom.sv | 11 +
 rtl/dezigzag_rowbuffer64x8bit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dezigzag_rowbuffer64x8bit_pkg.sv
// Shared definitions for the inverse-zigzag row buffer: FSM states and the
// standard JPEG zigzag-to-raster table used by the decoder reorder path.
package dezigzag_rowbuffer64x8bit_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } dz_state_t;

    localparam int BLOCK_SIZE = 64;
    localparam int ROW_COUNT  = 8;

    // Entry k gives the raster position (row*8 + col) of the k-th coefficient
    localparam logic [5:0] ZZ2RASTER [BLOCK_SIZE] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    function automatic logic [5:0] raster_to_zz(input logic [5:0] raster);
        raster_to_zz = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (ZZ2RASTER[i] == raster) begin
                raster_to_zz = 6'(i);
            end
        end
    endfunction

endpackage

// File: rtl/dezigzag_rowbuffer64x8bit_zigzag_index_rom.sv
// Combinational lookup from zigzag sequence number k to raster buffer index.
module zigzag_index_rom
    import dezigzag_rowbuffer64x8bit_pkg::*;
(
    input  logic [5:0] k,
    output logic [5:0] raster_idx
);

    assign raster_idx = ZZ2RASTER[k];

endmodule

// File: rtl/dezigzag_rowbuffer64x8bit.sv
// Inverse-zigzag buffer: collects one 8x8 block in zigzag order, then emits it
// as eight raster rows with valid/ready handshaking on both sides.
module dezigzag_rowbuffer64x8bit
    import dezigzag_rowbuffer64x8bit_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    coef_valid,
    output logic                    coef_ready,
    input  logic [DATA_WIDTH-1:0]   coef_data,
    input  logic                    coef_last,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic [7:0]              matrix_row,
    output logic [8*DATA_WIDTH-1:0] row_data,
    output logic                    block_done
);

    localparam int ROW_W = 8 * DATA_WIDTH;

    dz_state_t             state, state_next;
    logic [5:0]            k;
    logic [5:0]            wr_idx;
    logic [2:0]            row_cnt;
    logic [2:0]            load_sel;
    logic [DATA_WIDTH-1:0] buffer [DEPTH];
    logic [DEPTH-1:0]      mask;
    logic                  accept;
    logic                  block_end;
    logic                  row_take;
    logic                  last_take;
    logic [ROW_W-1:0]      row_next;
    logic [5:0]            gather_idx;
    logic [DATA_WIDTH-1:0] gather_byte;

    zigzag_index_rom u_zigzag_index_rom (
        .k          (k),
        .raster_idx (wr_idx)
    );

    assign accept    = coef_valid && coef_ready;
    assign block_end = accept && (coef_last || (k == 6'd63));
    assign row_take  = (state == DRAIN) && row_valid && row_ready;
    assign last_take = row_take && (row_cnt == 3'd7);
    assign load_sel  = block_end ? 3'd0 : row_cnt + 3'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (block_end) state_next = DRAIN;
            DRAIN:   if (last_take) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Row being loaded; the coefficient accepted this cycle is bypassed in so
    // row 0 can appear the cycle right after the final accept.
    always_comb begin
        row_next    = '0;
        gather_idx  = '0;
        gather_byte = '0;
        for (int c = 0; c < 8; c++) begin
            gather_idx  = {load_sel, 3'(c)};
            gather_byte = mask[gather_idx] ? buffer[gather_idx] : '0;
            if (accept && (wr_idx == gather_idx)) begin
                gather_byte = coef_data;
            end
            row_next[ROW_W-1-c*DATA_WIDTH -: DATA_WIDTH] = gather_byte;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k          <= '0;
            row_cnt    <= '0;
            mask       <= '0;
            row_valid  <= 1'b0;
            matrix_row <= '0;
            row_data   <= '0;
            block_done <= 1'b0;
            coef_ready <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            block_done <= 1'b0;
            coef_ready <= (state_next == FILL);
            if (accept) begin
                buffer[wr_idx] <= coef_data;
                mask[wr_idx]   <= 1'b1;
                k              <= k + 6'd1;
            end
            if (block_end) begin
                k          <= '0;
                row_cnt    <= '0;
                row_valid  <= 1'b1;
                matrix_row <= '0;
                row_data   <= row_next;
            end
            // Stale buffer bytes stay behind; clearing the mask hides them
            if (row_take) begin
                if (last_take) begin
                    row_valid  <= 1'b0;
                    block_done <= 1'b1;
                    mask       <= '0;
                    row_cnt    <= '0;
                end else begin
                    row_cnt    <= row_cnt + 3'd1;
                    matrix_row <= {5'b0, row_cnt + 3'd1};
                    row_data   <= row_next;
                end
            end
        end
    end

endmodule
